cgra_col_obi_arbiter: RTL



---
 rtl/cgra_col_obi_arbiter_if.sv | 26 ++
 rtl/cgra_col_obi_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cgra_col_obi_arbiter_if.sv
// OBI request/response types and the bundled port interface used on both the
// column side (N entries) and the crossbar side (one entry).
package cgra_col_obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

interface cgra_col_obi_if #(parameter int N = 1);
    import cgra_col_obi_pkg::*;
    obi_req_t  [N-1:0] req;
    obi_resp_t [N-1:0] resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/cgra_col_obi_arbiter.sv
// Round-robin merge of CGRA column OBI masters onto one crossbar port, with a
// locked grant and an in-order ID FIFO that routes responses back to columns.
module cgra_col_obi_port
    import cgra_col_obi_pkg::*;
#(
    parameter int IW = 2,
    parameter int ID = 0
) (
    input  logic [IW-1:0] sel,
    input  logic [IW-1:0] head,
    input  logic          hs,
    input  logic          pop,
    input  logic [31:0]   rdata,
    output obi_resp_t     resp
);
    assign resp.gnt    = hs  && (sel  == IW'(ID));
    assign resp.rvalid = pop && (head == IW'(ID));
    assign resp.rdata  = rdata;
endmodule

module cgra_col_obi_arbiter
    import cgra_col_obi_pkg::*;
#(
    parameter int N_MASTERS       = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    cgra_col_obi_if.slave    col,
    cgra_col_obi_if.master   bus,
    output logic             orphan_err_o
);
    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IW-1:0]  rr_ptr, lock_id_q, sel, sel_scan, head;
    logic           lock_q, orphan_err_q;
    logic [IW-1:0]  fifo_q [MAX_OUTSTANDING];
    logic [FW-1:0]  wr_ptr, rd_ptr;
    logic [FW:0]    cnt;
    logic [N_MASTERS-1:0] col_req;
    logic [IW:0]    idx_w;
    logic           found, fifo_full, fifo_empty, bus_valid, hs, pop;

    function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
        return (p == FW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // First requester at or after rr_ptr, wrapping at N_MASTERS.
    always_comb begin
        sel_scan = '0;
        found    = 1'b0;
        idx_w    = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx_w = {1'b0, rr_ptr} + (IW+1)'(i);
            if (idx_w >= (IW+1)'(N_MASTERS)) idx_w = idx_w - (IW+1)'(N_MASTERS);
            if (!found && col_req[idx_w[IW-1:0]]) begin
                found    = 1'b1;
                sel_scan = idx_w[IW-1:0];
            end
        end
    end

    assign sel        = lock_q ? lock_id_q : sel_scan;
    assign fifo_full  = (cnt == (FW+1)'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt == '0);
    // Full masks the request regardless of a same-cycle pop, so req never depends on rvalid.
    assign bus_valid  = rst_ni && (found || lock_q) && !fifo_full;
    assign hs         = bus_valid && bus.resp[0].gnt;
    assign pop        = rst_ni && bus.resp[0].rvalid && !fifo_empty;
    assign head       = fifo_q[rd_ptr];
    assign orphan_err_o = orphan_err_q;

    always_comb begin
        bus.req[0] = '0;
        if (bus_valid) begin
            bus.req[0]     = col.req[sel];
            bus.req[0].req = 1'b1;
        end
    end

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_col
        assign col_req[i] = col.req[i].req;

        cgra_col_obi_port #(.IW(IW), .ID(i)) u_port (
            .sel   (sel),
            .head  (head),
            .hs    (hs),
            .pop   (pop),
            .rdata (bus.resp[0].rdata),
            .resp  (col.resp[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (hs) fifo_q[wr_ptr] <= sel;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr       <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            orphan_err_q <= 1'b0;
        end else begin
            if (hs) begin
                wr_ptr <= ptr_inc(wr_ptr);
                rr_ptr <= (sel == IW'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
                lock_q <= 1'b0;
            end else if (bus_valid) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({hs, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (bus.resp[0].rvalid && fifo_empty) orphan_err_q <= 1'b1;
        end
    end
endmodule
